sort_batch_ctrl: RTL and testbench
==================================

# sort_batch_ctrl

Batch sequencer for the 32-input odd-even merge sorting network. Accepts 29-bit records one per cycle over a valid/ready stream and collects them into a 32-slot load buffer. It holds the buffer stable on the sorter's inputs for a programmable settle window, captures the sorted result and streams it out in ascending order. It sits between the record producer and the pixel-ordering consumer; the combinational sorter is instantiated beside it and wired to `sort_in`/`sort_out`.

## Interface

**Parameters**
- `W`, 29: record width (5b index, 2b class, 6b, 8b, 8b fields); treated as an opaque unsigned key.
- `N`, 32: batch size; fixed by the sorter port count.
- `SORT_WAIT`, 2: settle cycles allowed for the combinational sorter path (1–15).

**Ports**
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: input record valid.
- `in_ready`, output, 1: controller accepts a record.
- `in_data`, input, W: input record.
- `in_last`, input, 1: final record of a short batch; honoured only with `SORT_PAD_EN`.
- `sort_in`, output, N*W: load buffer; slot k at `[k*W +: W]`.
- `sort_out`, input, N*W: sorter result; slot 0 is the smallest key.
- `out_valid`, output, 1: output record valid.
- `out_ready`, input, 1: consumer accepts.
- `out_data`, output, W: sorted record.
- `out_last`, output, 1: final valid record of the batch.
- `out_count`, output, 6: real (non-pad) records in the current batch, 1–32.
- `busy`, output, 1: state is not LOAD.
- `batch_done`, output, 1: one-cycle pulse after the last output handshake.

## Operation

- FSM states: IDLE, LOAD, SORT, DRAIN. Encoding is free.
- **IDLE:** entered only by reset; moves to LOAD unconditionally on the next edge.
- **LOAD:**
  - `in_ready`=1.
  - Each `in_valid&in_ready` writes `in_data` to slot `wr_cnt`, then increments `wr_cnt`.
  - On the accept with `wr_cnt`=31, or an accepted `in_last`: latch `out_count`=`wr_cnt`+1, clear `wait_cnt`, go to SORT.
- **Padding:** at the SORT transition, slots ≥ `out_count` are set to all-ones (29'h1FFFFFFF), so pads sort to the top.
- **SORT:**
  - `in_ready`=0; `sort_in` is held constant.
  - `wait_cnt` increments each cycle.
  - When `wait_cnt`==`SORT_WAIT`-1: capture `sort_out` into the 32-slot output buffer, clear `rd_cnt`, go to DRAIN.
- **DRAIN:**
  - `out_valid`=1, `out_data`=`obuf[rd_cnt]`, `out_last`=(`rd_cnt`==`out_count`-1).
  - Each handshake increments `rd_cnt`.
  - On the `out_last` handshake: pulse `batch_done`, clear `wr_cnt`, go to LOAD.
  - Pad slots are never emitted.
- **Ties:** equal keys may leave in any relative order.
- **Width rules:** `wr_cnt`/`rd_cnt` are 6 bits (0–32); `wait_cnt` is 4 bits.
- **`in_last` on the 32nd record:** the batch is full and no padding is applied.
- `in_valid` outside LOAD is ignored (not accepted).
- **Stall:** `out_ready` low holds `out_data`/`out_last` stable.

## Timing

- **Reset values:** state=IDLE; `in_ready`=0, `out_valid`=0, `out_last`=0, `busy`=1, `batch_done`=0; `out_data`=0, `out_count`=0, `sort_in`=0; all counters 0.
- `in_ready` first rises one cycle after `rst_n` deasserts (the IDLE→LOAD edge).
- **Full batch latency:** 32 accept cycles, then `SORT_WAIT` cycles in SORT. `out_valid` rises on the edge that ends the last SORT cycle. Minimum 32+`SORT_WAIT` cycles from first accept to first output.
- **DRAIN throughput:** one record per cycle with `out_ready` held high.
- **LOAD re-entry:** `in_ready` rises the cycle after the final output handshake. Input and output phases do not overlap.
- `busy` and `in_ready` are mutually exclusive after IDLE.
- **Reset asserted mid-batch:** the partial batch is discarded, outputs return to reset values immediately (asynchronously), and nothing partial is emitted afterwards.

## Configuration

- `SORT_PAD_EN` defined:
  - `in_last` closes a short batch.
  - Padding logic and a variable `out_count` are present.
- `SORT_PAD_EN` undefined:
  - `in_last` is ignored and every batch is exactly 32 records.
  - `out_count` is tied to 32 and no pad muxes are built.

## Test plan

- **Full batch:** reset, then load records with keys 31 down to 0 (index field = key), `SORT_WAIT`=2, `out_ready`=1. Outputs are keys 0..31 on consecutive cycles, `out_last` on key 31, `batch_done` one cycle later, `in_ready`=1 the same cycle.
- **Short batch (`SORT_PAD_EN`):** 5 records {9,3,7,1,5} with `in_last` on the 5th. `out_count`=5; outputs 1,3,5,7,9 with `out_last` on 9; no all-ones record emitted.
- **Backpressure:** drop `out_ready` for 3 cycles mid-DRAIN at `rd_cnt`=10. `out_data` is held at the 11th-smallest key; no record is skipped or duplicated.
- **Input gaps:** toggle `in_valid` 1/0 throughout LOAD and hold `in_valid`=1 during SORT/DRAIN. Exactly 32 records are accepted; extra inputs are not consumed (`in_ready`=0).
- **Reset mid-operation:** assert `rst_n`=0 during SORT cycle 1 and again during DRAIN at `rd_cnt`=4. Outputs return to reset values immediately; the next full batch sorts correctly.
- **Duplicates:** 32 records that include 8 copies of 29'h0000102 among distinct keys. The multiset out equals the multiset in, in nondecreasing order.

Source files
------------

// File: rtl/sort_batch_ctrl.sv
// sort_batch_ctrl: batch sequencer for the 32-input odd-even merge sorter.
//   Collects W-bit records into an N-slot load buffer over a valid/ready
//   stream. It then holds the buffer on sort_in for SORT_WAIT settle cycles,
//   captures sort_out, and streams the sorted records out in ascending order.
// Ports:
//   clk, rst_n (async, active-low)
//   in_valid/in_ready/in_data/in_last : record input stream (LOAD only)
//   sort_in  : load buffer to the sorter, slot k at [k*W +: W]
//   sort_out : sorter result, slot 0 smallest
//   out_valid/out_ready/out_data/out_last : sorted output stream (DRAIN only)
//   out_count : real records in the batch; busy : not in LOAD
//   batch_done : one-cycle pulse after the final output handshake
// Build option: SORT_PAD_EN. When it is defined, in_last closes a short batch,
//   unused slots are padded with all-ones, and out_count is variable.
//   When it is undefined, every batch holds N records and out_count is tied to N.
module sort_batch_ctrl #(
  parameter int W         = 29,
  parameter int N         = 32,
  parameter int SORT_WAIT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           in_last,
  output logic [N*W-1:0] sort_in,
  input  logic [N*W-1:0] sort_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [5:0]     out_count,
  output logic           busy,
  output logic           batch_done
);
  localparam int AW = $clog2(N);

  typedef enum logic [1:0] {IDLE, LOAD, SORT, DRAIN} state_t;
  state_t state, state_nxt;

  logic [N-1:0][W-1:0] lbuf, obuf;
  logic [5:0]          wr_cnt, rd_cnt;
  logic [3:0]          wait_cnt;
  logic                accept, close, settled, out_hs, done;

  assign in_ready  = (state == LOAD);
  assign busy      = (state != LOAD);
  assign out_valid = (state == DRAIN);
  assign accept    = in_valid & in_ready;
  assign sort_in   = lbuf;
  assign settled   = (state == SORT) && (wait_cnt == 4'(SORT_WAIT - 1));
  assign out_last  = out_valid && (rd_cnt == out_count - 6'd1);
  assign out_data  = out_valid ? obuf[rd_cnt[AW-1:0]] : '0;
  assign out_hs    = out_valid & out_ready;
  assign done      = out_hs & out_last;

`ifdef SORT_PAD_EN
  logic [5:0] cnt_q;
  // in_last on the final slot closes a full batch, so no padding is applied.
  assign close     = accept & ((wr_cnt == 6'(N - 1)) | in_last);
  assign out_count = cnt_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     cnt_q <= '0;
    else if (close) cnt_q <= wr_cnt + 6'd1;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign close          = accept & (wr_cnt == 6'(N - 1));
  assign out_count      = 6'(N);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = LOAD;
      LOAD:    if (close)   state_nxt = SORT;
      SORT:    if (settled) state_nxt = DRAIN;
      DRAIN:   if (done)    state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Load buffer. The closing write of a short batch pads every higher slot
  // in the same edge, so that pads sort to the top of the output.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lbuf <= '0;
    else
      for (int k = 0; k < N; k++) begin
        if (accept && wr_cnt == 6'(k)) lbuf[k] <= in_data;
`ifdef SORT_PAD_EN
        else if (close && wr_cnt < 6'(k)) lbuf[k] <= '1;
`endif
      end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      wait_cnt   <= '0;
      batch_done <= 1'b0;
      obuf       <= '0;
    end else begin
      batch_done <= done;
      if (accept)    wr_cnt <= wr_cnt + 6'd1;
      else if (done) wr_cnt <= '0;
      if (close)               wait_cnt <= '0;
      else if (state == SORT)  wait_cnt <= wait_cnt + 4'd1;
      if (settled)     rd_cnt <= '0;
      else if (out_hs) rd_cnt <= rd_cnt + 6'd1;
      if (settled) obuf <= sort_out;
    end
endmodule

// File: tb/tb_sort_batch_ctrl.sv
module tb_sort_batch_ctrl;
  localparam int W = 29;
  localparam int N = 32;

  logic           clk = 1'b0, rst_n = 1'b0;
  logic           in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [W-1:0]   in_data = '0;
  logic           in_ready, out_valid, out_last, busy, batch_done;
  logic [W-1:0]   out_data;
  logic [5:0]     out_count;
  logic [N*W-1:0] sort_in, sort_out;

  int n_cmp = 0, n_err = 0, acc_cnt = 0;
  logic [W-1:0] vin  [N];
  logic [W-1:0] vexp [N];

  always #5 clk = ~clk;

  sort_batch_ctrl #(.W(W), .N(N), .SORT_WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .sort_in(sort_in), .sort_out(sort_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_count(out_count), .busy(busy), .batch_done(batch_done)
  );

  // Behavioural stand-in for the combinational sorting network
  function automatic logic [N*W-1:0] sort_fn(input logic [N*W-1:0] v);
    logic [W-1:0]   a [N];
    logic [W-1:0]   tmp;
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) a[i] = v[i*W +: W];
    for (int i = 1; i < N; i++)
      for (int j = i; j > 0; j--)
        if (a[j-1] > a[j]) begin tmp = a[j]; a[j] = a[j-1]; a[j-1] = tmp; end
    for (int i = 0; i < N; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  always_comb sort_out = sort_fn(sort_in);

  always @(posedge clk) if (rst_n && in_valid && in_ready) acc_cnt <= acc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int n, input bit gap, input bit last_flag, input bit hold);
    int t;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = vin[j]; in_last = last_flag && (j == n - 1);
      t = 0;
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin chk("load_to", 32'(in_ready), 32'd1); in_valid = 1'b0; return; end
      @(posedge clk); #1;
      in_valid = hold && (j == n - 1); in_data = '0; in_last = 1'b0;
      if (gap && j != n - 1) @(posedge clk);
    end
  endtask

  task automatic drain(input int total, input int stop, input int stall_at, output int first_t);
    int i, t, s;
    i = 0; t = 0; s = 0; first_t = -1;
    while (i < stop && t < 300) begin
      @(negedge clk); t++;
      if (out_valid) begin
        if (first_t < 0) first_t = t;
        chk("out_data", 32'(out_data), 32'(vexp[i]));
        chk("out_last", 32'(out_last), 32'(i == total - 1));
        out_ready = !(i == stall_at && s < 3);
        if (!out_ready) s++;
        if (out_ready && i == total - 1) in_valid = 1'b0;
        @(posedge clk);
        if (out_ready) i++;
      end
    end
    out_ready = 1'b1;
    if (i < stop) chk("drain_to", i, stop);
    if (stop == total) begin
      @(negedge clk);
      chk("batch_done", 32'(batch_done), 32'd1);
      chk("reload_rdy", 32'(in_ready), 32'd1);
      chk("ov_after", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("done_pulse", 32'(batch_done), 32'd0);
    end
  endtask

  task automatic set_desc();
    for (int j = 0; j < N; j++) begin
      vin[j]  = W'(N - 1 - j) << 24;
      vexp[j] = W'(j) << 24;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rdy"},  32'(in_ready), 32'd0);
    chk({tag, "_ov"},   32'(out_valid), 32'd0);
    chk({tag, "_ol"},   32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_bd"},   32'(batch_done), 32'd0);
    chk({tag, "_od"},   32'(out_data), 32'd0);
    chk({tag, "_sin0"}, 32'(sort_in == '0), 32'd1);
`ifdef SORT_PAD_EN
    chk({tag, "_cnt"},  32'(out_count), 32'd0);
`else
    chk({tag, "_cnt"},  32'(out_count), 32'd32);
`endif
  endtask

  initial begin
    int ft, base, d;

    // Reset state, then first in_ready one cycle after release
    @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_rdy", 32'(in_ready), 32'd1);
    chk("first_busy", 32'(busy), 32'd0);

    // Full batch, keys 31..0 back-to-back
    set_desc();
    load(32, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("sort1_ov", 32'(out_valid), 32'd0);
    chk("sort1_rdy", 32'(in_ready), 32'd0);
    chk("sort1_busy", 32'(busy), 32'd1);
    chk("full_cnt", 32'(out_count), 32'd32);
    @(negedge clk);
    chk("sort2_ov", 32'(out_valid), 32'd0);
    drain(32, 32, -1, ft);
    chk("latency", ft, 1);

`ifdef SORT_PAD_EN
    // Short batch with padding
    vin[0] = 29'd9; vin[1] = 29'd3; vin[2] = 29'd7; vin[3] = 29'd1; vin[4] = 29'd5;
    vexp[0] = 29'd1; vexp[1] = 29'd3; vexp[2] = 29'd5; vexp[3] = 29'd7; vexp[4] = 29'd9;
    load(5, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("short_cnt", 32'(out_count), 32'd5);
    chk("pad_slot31", 32'(sort_in[31*W +: W]), 32'h1FFFFFFF);
    chk("pad_slot5", 32'(sort_in[5*W +: W]), 32'h1FFFFFFF);
    drain(5, 5, -1, ft);
`endif

    // Input gaps, in_valid held through SORT/DRAIN, backpressure at rd_cnt=10
    for (int j = 0; j < N; j++) begin
      vin[j]  = W'((j * 7) % 32) << 24;
      vexp[j] = W'(j) << 24;
    end
    base = acc_cnt;
    load(32, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("hold_rdy", 32'(in_ready), 32'd0);
    drain(32, 32, 10, ft);
    chk("acc_cnt", acc_cnt - base, 32);

    // Duplicates: eight copies of 0x102 among 24 distinct keys
    d = 0;
    for (int j = 0; j < N; j++) begin
      if (j % 4 == 0) vin[j] = 29'h102;
      else begin
        vin[j] = (d < 12) ? W'(29'h20B - d) : W'(12 - (d - 12));
        d++;
      end
    end
    for (int j = 0; j < N; j++)
      vexp[j] = (j < 12) ? W'(j + 1) : (j < 20) ? 29'h102 : W'(29'h200 + (j - 20));
    load(32, 1'b0, 1'b0, 1'b0);
    drain(32, 32, -1, ft);

    // Reset during SORT cycle 1
    set_desc();
    load(32, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_sort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rs_rdy", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("rs_noout", 32'(out_valid), 32'd0);

    // Reset during DRAIN at rd_cnt=4
    load(32, 1'b0, 1'b0, 1'b0);
    drain(32, 4, -1, ft);
    #1 rst_n = 1'b0;
    #1 check_reset("rst_drain");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rd_noout", 32'(out_valid), 32'd0);

    // Recovery batch
    load(32, 1'b0, 1'b0, 1'b0);
    drain(32, 32, -1, ft);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
